// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 3
);
    logic                  flush;
    logic [NUM_FU-1:0]     req_valid;
    logic [6*NUM_FU-1:0]   req_rd;
    logic [32*NUM_FU-1:0]  req_val;
    logic [5*NUM_FU-1:0]   req_rob;
    logic [NUM_FU-1:0]     req_ready;
    logic                  cdb_valid;
    logic [5:0]            cdb_rd;
    logic [31:0]           cdb_val;
    logic [4:0]            cdb_rob;
    logic [1:0]            cdb_fu;
    logic [63:0]           reg_ready_set;
    logic [31:0]           busy_cycles;

    // FU / pipeline side
    modport master (
        output flush, req_valid, req_rd, req_val, req_rob,
        input  req_ready, cdb_valid, cdb_rd, cdb_val, cdb_rob, cdb_fu,
               reg_ready_set, busy_cycles
    );

    // arbiter side
    modport slave (
        input  flush, req_valid, req_rd, req_val, req_rob,
        output req_ready, cdb_valid, cdb_rd, cdb_val, cdb_rob, cdb_fu,
               reg_ready_set, busy_cycles
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin grant, registered CDB.

// One FU result FIFO. Ready is registered from next-state occupancy, so a full
// FIFO never accepts a push even when it pops in the same cycle.
module cdb_fifo_lane #(
    parameter int DEPTH = 2,
    parameter int W     = 43
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         nonempty_o,
    output logic         ready_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q;
    logic          push_ok, pop_ok;

    assign push_ok    = push_i && ready_q && !flush_i;
    assign pop_ok     = pop_i && (cnt_q != '0) && !flush_i;
    assign data_o     = mem_q[rptr_q];
    assign nonempty_o = (cnt_q != '0);
    assign ready_o    = ready_q;

    // next occupancy; flush empties, simultaneous push+pop leaves it unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i)                cnt_d = '0;
        else if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
    end

    // pointers, occupancy and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d < CW'(DEPTH));
            if (flush_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push_ok) wptr_q <= wptr_q + PW'(1);
                if (pop_ok)  rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    // storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end
endmodule

module cdb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int NUM_FU = 3
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    // entry layout: {rd[5:0], val[31:0], rob[4:0]}
    localparam int W = 43;

    logic [NUM_FU-1:0][W-1:0] head;
    logic [NUM_FU-1:0]        nonempty, grant, ready;
    logic [1:0]               rr_q, rr_d, win;
    logic                     win_vld;
    logic [2:0]               cand;
    logic [W-1:0]             win_ent;

    logic        cdb_valid_q;
    logic [5:0]  cdb_rd_q;
    logic [31:0] cdb_val_q;
    logic [4:0]  cdb_rob_q;
    logic [1:0]  cdb_fu_q;
    logic [63:0] rrs_q;
    logic [31:0] busy_q;

    genvar k;
    generate
        for (k = 0; k < NUM_FU; k++) begin : g_lane
            cdb_fifo_lane #(.DEPTH(DEPTH), .W(W)) u_lane (
                .clk        (clk),
                .rst        (rst),
                .flush_i    (bus.flush),
                .push_i     (bus.req_valid[k]),
                .pop_i      (grant[k]),
                .data_i     ({bus.req_rd[6*k +: 6], bus.req_val[32*k +: 32], bus.req_rob[5*k +: 5]}),
                .data_o     (head[k]),
                .nonempty_o (nonempty[k]),
                .ready_o    (ready[k])
            );
        end
    endgenerate

    // round-robin search from rr_q; iterating backwards lets the first hit win
    always_comb begin
        win_vld = 1'b0;
        win     = rr_q;
        cand    = '0;
        grant   = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + 3'(i);
            if (cand >= 3'(NUM_FU)) cand = cand - 3'(NUM_FU);
            if (nonempty[cand[1:0]]) begin
                win_vld = 1'b1;
                win     = cand[1:0];
            end
        end
        if (win_vld && !bus.flush) grant[win] = 1'b1;
        rr_d = rr_q;
        if (bus.flush)    rr_d = 2'd0;
        else if (win_vld) rr_d = (win == 2'(NUM_FU - 1)) ? 2'd0 : win + 2'd1;
        win_ent = head[win];
    end

    // registered CDB, wakeup vector, rr pointer and saturating busy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_rd_q    <= '0;
            cdb_val_q   <= '0;
            cdb_rob_q   <= '0;
            cdb_fu_q    <= '0;
            rrs_q       <= '0;
            busy_q      <= '0;
        end else begin
            rr_q <= rr_d;
            if (bus.flush || !win_vld) begin
                cdb_valid_q <= 1'b0;
                cdb_rd_q    <= '0;
                cdb_val_q   <= '0;
                cdb_rob_q   <= '0;
                cdb_fu_q    <= '0;
                rrs_q       <= '0;
            end else begin
                cdb_valid_q <= 1'b1;
                cdb_rd_q    <= win_ent[W-1 -: 6];
                cdb_val_q   <= win_ent[36:5];
                cdb_rob_q   <= win_ent[4:0];
                cdb_fu_q    <= win;
                rrs_q       <= (win_ent[W-1 -: 6] != 6'd0) ? (64'd1 << win_ent[W-1 -: 6]) : 64'd0;
                if (busy_q != 32'hFFFF_FFFF) busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign bus.req_ready     = ready;
    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_rd        = cdb_rd_q;
    assign bus.cdb_val       = cdb_val_q;
    assign bus.cdb_rob       = cdb_rob_q;
    assign bus.cdb_fu        = cdb_fu_q;
    assign bus.reg_ready_set = rrs_q;
    assign bus.busy_cycles   = busy_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table plus directed multi-cycle sequences.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(3)) bus();
    cdb_arbiter #(.DEPTH(2), .NUM_FU(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          fu;
        logic [5:0]  rd;
        logic [31:0] val;
        logic [4:0]  rob;
        logic [63:0] rrs;
    } rec_t;

    rec_t exp_q[$];
    int   exp_fu_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_bcast = 0;

    function automatic logic [63:0] rrs_of(input logic [5:0] rd);
        return (rd == 6'd0) ? 64'd0 : (64'd1 << rd);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one cycle of stimulus; accepted pushes go to the scoreboard after the edge
    task automatic drive(input logic [2:0] v, input logic [17:0] rd, input logic [95:0] val,
                         input logic [14:0] rob, input logic fl, output logic [2:0] acc);
        logic [2:0] rdy;
        bus.req_valid = v;
        bus.req_rd    = rd;
        bus.req_val   = val;
        bus.req_rob   = rob;
        bus.flush     = fl;
        rdy = bus.req_ready;
        acc = fl ? 3'b000 : (v & rdy);
        tick();
        for (int k = 0; k < 3; k++)
            if (acc[k]) exp_q.push_back('{k, rd[6*k +: 6], val[32*k +: 32], rob[5*k +: 5], rrs_of(rd[6*k +: 6])});
        if (fl) begin
            exp_q.delete();
            exp_fu_q.delete();
        end
        bus.req_valid = '0;
        bus.flush     = 1'b0;
    endtask

    // monitor: every broadcast must match the oldest pending result of its FU
    always @(negedge clk) begin
        int   found;
        rec_t e;
        if (!rst) begin
            if (bus.cdb_valid === 1'b1) begin
                n_bcast++;
                found = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (found < 0 && exp_q[i].fu == int'(bus.cdb_fu)) found = i;
                if (found < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bcast: fu=%0d rob=%0d rd=%0d, none pending", bus.cdb_fu, bus.cdb_rob, bus.cdb_rd);
                end else begin
                    e = exp_q[found];
                    exp_q.delete(found);
                    chk("cdb_rd", 64'(bus.cdb_rd), 64'(e.rd));
                    chk("cdb_val", 64'(bus.cdb_val), 64'(e.val));
                    chk("cdb_rob", 64'(bus.cdb_rob), 64'(e.rob));
                    chk("reg_ready_set", bus.reg_ready_set, e.rrs);
                end
                if (exp_fu_q.size() > 0) chk("grant_order", 64'(bus.cdb_fu), 64'(exp_fu_q.pop_front()));
            end else begin
                chk("idle_reg_ready_set", bus.reg_ready_set, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t        vec[5];
        logic [2:0]  acc;
        logic [17:0] rdb;
        logic [95:0] valb;
        logic [14:0] robb;
        logic [31:0] bb;
        int          idx[3];
        int          occ2, cyc;
        bit          saw_low;

        vec[0] = '{1, 6'd5,  32'hDEADBEEF, 5'd3,  64'h20};
        vec[1] = '{2, 6'd0,  32'h0000_1234, 5'd9,  64'h0};
        vec[2] = '{0, 6'd63, 32'hFFFF_FFFF, 5'd31, 64'h8000_0000_0000_0000};
        vec[3] = '{2, 6'd1,  32'h0,         5'd0,  64'h2};
        vec[4] = '{0, 6'd32, 32'hA5A5_5A5A, 5'd17, 64'h1_0000_0000};

        bus.flush = 1'b0; bus.req_valid = '0; bus.req_rd = '0; bus.req_val = '0; bus.req_rob = '0;
        rst = 1'b1;
        #1;
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy_cycles), 64'd0);
        chk("rst_rrs", bus.reg_ready_set, 64'd0);
        #11 rst = 1'b0;
        tick();
        chk("ready_after_rst", 64'(bus.req_ready), 64'h7);
        repeat (5) begin
            tick();
            chk("idle_valid", 64'(bus.cdb_valid), 64'd0);
        end
        chk("idle_busy", 64'(bus.busy_cycles), 64'd0);

        // simultaneous pushes from all FUs, twice: order 0,1,2 and rr returns to 0
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) exp_fu_q.push_back(k);
            drive(3'b111, {6'd3, 6'd2, 6'd1}, {32'h333, 32'h222, 32'h111}, {5'd12, 5'd11, 5'd10}, 1'b0, acc);
            chk("simul_acc", 64'(acc), 64'h7);
            repeat (5) tick();
            chk("simul_drained", 64'(exp_q.size() + exp_fu_q.size()), 64'd0);
            chk("simul_busy", 64'(bus.busy_cycles), 64'(3 * (r + 1)));
        end

        // vector table: single pushes, two-edge latency, explicit outputs
        for (int i = 0; i < 5; i++) begin
            rdb = '0; valb = '0; robb = '0;
            rdb[6*vec[i].fu +: 6]   = vec[i].rd;
            valb[32*vec[i].fu +: 32] = vec[i].val;
            robb[5*vec[i].fu +: 5]  = vec[i].rob;
            drive(3'(1 << vec[i].fu), rdb, valb, robb, 1'b0, acc);
            chk("vec_no_bypass", 64'(bus.cdb_valid), 64'd0);
            tick();
            chk("vec_valid", 64'(bus.cdb_valid), 64'd1);
            chk("vec_fu", 64'(bus.cdb_fu), 64'(vec[i].fu));
            chk("vec_rd", 64'(bus.cdb_rd), 64'(vec[i].rd));
            chk("vec_rrs", bus.reg_ready_set, vec[i].rrs);
            tick();
            chk("vec_valid_drop", 64'(bus.cdb_valid), 64'd0);
        end

        // flush on an empty arbiter resets rr, then a backpressured stream
        drive(3'b000, '0, '0, '0, 1'b1, acc);
        for (int i = 0; i < 6; i++) for (int k = 0; k < 3; k++) exp_fu_q.push_back(k);
        idx = '{0, 0, 0}; occ2 = 0; cyc = 0; saw_low = 0;
        while ((idx[0] < 6 || idx[1] < 6 || idx[2] < 6) && cyc < 200) begin
            rdb = '0; valb = '0; robb = '0;
            for (int k = 0; k < 3; k++) begin
                rdb[6*k +: 6]   = 6'(k * 10 + idx[k] + 1);
                valb[32*k +: 32] = $urandom;
                robb[5*k +: 5]  = 5'(k * 8 + idx[k]);
            end
            drive({idx[2] < 6, idx[1] < 6, idx[0] < 6}, rdb, valb, robb, 1'b0, acc);
            for (int k = 0; k < 3; k++) if (acc[k]) idx[k]++;
            if (acc[2]) occ2++;
            if (bus.cdb_valid && bus.cdb_fu == 2'd2) occ2--;
            chk("ready2_vs_occupancy", 64'(bus.req_ready[2]), 64'(occ2 < 2));
            if (!bus.req_ready[2]) saw_low = 1;
            cyc++;
        end
        chk("stream_bound", 64'(cyc < 200), 64'd1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 30) begin
            tick();
            cyc++;
        end
        tick();
        chk("stream_drained", 64'(exp_q.size() + exp_fu_q.size()), 64'd0);
        chk("stream_backpressure_seen", 64'(saw_low), 64'd1);
        chk("stream_busy", 64'(bus.busy_cycles), 64'(n_bcast));

        // fill all FIFOs, then flush with a simultaneous FU0 push
        for (int r = 0; r < 3; r++)
            drive(3'b111, {6'd9, 6'd8, 6'd7}, {3{32'hCAFE_0000 + 32'(r)}}, {5'(20 + r), 5'(23 + r), 5'(26 + r)}, 1'b0, acc);
        bb = bus.busy_cycles;
        drive(3'b001, {12'd0, 6'd40}, {64'd0, 32'hBAD0_BAD0}, {10'd0, 5'd30}, 1'b1, acc);
        chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("flush_ready", 64'(bus.req_ready), 64'h7);
        chk("flush_busy_hold", 64'(bus.busy_cycles), 64'(bb));
        repeat (5) tick();
        chk("post_flush_busy", 64'(bus.busy_cycles), 64'(bb));
        chk("post_flush_count", 64'(bus.busy_cycles), 64'(n_bcast));

        // asynchronous reset mid-stream drops everything immediately
        drive(3'b111, {6'd4, 6'd5, 6'd6}, {32'h1, 32'h2, 32'h3}, {5'd1, 5'd2, 5'd3}, 1'b0, acc);
        drive(3'b111, {6'd4, 6'd5, 6'd6}, {32'h4, 32'h5, 32'h6}, {5'd4, 5'd5, 5'd6}, 1'b0, acc);
        #3 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.cdb_valid), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd0);
        chk("midrst_busy", 64'(bus.busy_cycles), 64'd0);
        chk("midrst_rrs", bus.reg_ready_set, 64'd0);
        exp_q.delete();
        exp_fu_q.delete();
        n_bcast = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        chk("midrst_ready_back", 64'(bus.req_ready), 64'h7);
        drive(3'b100, {6'd7, 12'd0}, {32'h7777_7777, 64'd0}, {5'd12, 10'd0}, 1'b0, acc);
        repeat (3) tick();
        chk("midrst_repush_drained", 64'(exp_q.size()), 64'd0);
        chk("midrst_repush_busy", 64'(bus.busy_cycles), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
